// File: rtl/atp.sv
// Any-Time-Payment kiosk controller: scans a bill code, takes cheque/DD/card/cash
// payments against the balance, and ends the session on settle, cancel or timeout.
module atp #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_payment,
    input  logic [3:0]  barcode,
    input  logic [3:0]  choice,
    input  logic        cheque_inserted,
    input  logic [7:0]  cheque_amount,
    input  logic        dd_inserted,
    input  logic [7:0]  dd_amount,
    input  logic        card_inserted,
    input  logic [15:0] card_number,
    input  logic [3:0]  card_choice,
    input  logic [7:0]  card_amount,
    input  logic        currency_inserted,
    input  logic [7:0]  currency_amount,
    output logic [7:0]  remaining_amount,
    output logic        payment_complete,
    output logic        line_disconnected,
    output logic [2:0]  state_dbg
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_SELECT, S_CHEQUE, S_DD, S_CARD, S_CASH, S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      rem_q, rem_d;
    logic            complete_q, complete_d;
    logic            line_q, line_d;
    logic [3:0]      barcode_q, barcode_d;
    logic [7:0]      amt_q, amt_d;
    logic            card_ok_q, card_ok_d;
    logic            ins_prev_q, ins_prev_d;
    logic            start_prev_q;
    logic [TW-1:0]   timer_q, timer_d;

    logic            start_rise;
    logic            ins_sel;
    logic [7:0]      amt_sel;
    logic            card_ok_now;
    logic [7:0]      pay;
    logic [7:0]      rem_after;
    logic            commit;
    logic            ins_edge;
    logic            timed_out;

    assign start_rise  = start_payment & ~start_prev_q;
    assign card_ok_now = (card_number != 16'd0) && (card_choice <= 4'd1);
    assign pay         = (amt_q < rem_q) ? amt_q : rem_q;
    assign rem_after   = rem_q - pay;
    assign commit      = ins_prev_q & ~ins_sel;
    assign ins_edge    = ins_sel ^ ins_prev_q;
    assign timed_out   = (timer_q == TW'(TIMEOUT - 1));

    // Only the instrument belonging to the current wait state is observed.
    always_comb begin
        ins_sel = 1'b0;
        amt_sel = 8'd0;
        case (state_q)
            S_CHEQUE: begin ins_sel = cheque_inserted;   amt_sel = cheque_amount;   end
            S_DD:     begin ins_sel = dd_inserted;       amt_sel = dd_amount;       end
            S_CARD:   begin ins_sel = card_inserted;     amt_sel = card_amount;     end
            S_CASH:   begin ins_sel = currency_inserted; amt_sel = currency_amount; end
            default:  ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        complete_d = complete_q;
        barcode_d  = barcode_q;
        amt_d      = amt_q;
        card_ok_d  = card_ok_q;
        ins_prev_d = ins_sel;
        timer_d    = timer_q;

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d    = S_SCAN;
                    complete_d = 1'b0;
                    barcode_d  = barcode;
                end
            end
            S_SCAN: begin
                if (start_payment) begin
                    barcode_d = barcode;
                end else if (barcode_q != 4'd0) begin
                    rem_d   = {barcode_q, 4'b0000};
                    state_d = S_SELECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SELECT: begin
                if (start_rise) begin
                    state_d    = S_IDLE;
                    rem_d      = 8'd0;
                    complete_d = 1'b0;
                end else begin
                    case (choice)
                        4'd1:    state_d = S_CHEQUE;
                        4'd2:    state_d = S_DD;
                        4'd3:    state_d = S_CARD;
                        4'd4:    state_d = S_CASH;
                        default: begin
                            if (timed_out) begin
                                state_d    = S_IDLE;
                                rem_d      = 8'd0;
                                complete_d = 1'b0;
                            end else begin
                                timer_d = timer_q + TW'(1);
                            end
                        end
                    endcase
                end
            end
            S_CHEQUE, S_DD, S_CARD, S_CASH: begin
                if (start_rise) begin
                    state_d    = S_IDLE;
                    rem_d      = 8'd0;
                    complete_d = 1'b0;
                end else begin
                    if (ins_sel) begin
                        amt_d = amt_sel;
                        if (state_q == S_CARD) begin
                            card_ok_d = card_ok_now;
                        end
                    end
                    if (commit) begin
                        // A rejected card returns to SELECT without touching the balance.
                        if (state_q == S_CARD && !card_ok_q) begin
                            state_d = S_SELECT;
                        end else begin
                            rem_d = rem_after;
                            if (rem_after == 8'd0) begin
                                state_d    = S_DONE;
                                complete_d = 1'b1;
                            end else begin
                                state_d = S_SELECT;
                            end
                        end
                    end else if (ins_edge) begin
                        timer_d = '0;
                    end else if (timed_out) begin
                        state_d    = S_IDLE;
                        rem_d      = 8'd0;
                        complete_d = 1'b0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new state starts with a fresh idle count and no instrument seen yet.
        if (state_d != state_q) begin
            timer_d    = '0;
            ins_prev_d = 1'b0;
        end

        line_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rem_q        <= 8'd0;
            complete_q   <= 1'b0;
            line_q       <= 1'b1;
            barcode_q    <= 4'd0;
            amt_q        <= 8'd0;
            card_ok_q    <= 1'b0;
            ins_prev_q   <= 1'b0;
            start_prev_q <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            complete_q   <= complete_d;
            line_q       <= line_d;
            barcode_q    <= barcode_d;
            amt_q        <= amt_d;
            card_ok_q    <= card_ok_d;
            ins_prev_q   <= ins_prev_d;
            start_prev_q <= start_payment;
            timer_q      <= timer_d;
        end
    end

    assign remaining_amount  = rem_q;
    assign payment_complete  = complete_q;
    assign line_disconnected = line_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_atp.sv
// Bench for atp: a session-level reference model predicts outputs each cycle,
// a monitor compares them, and directed scenarios add fixed-value spot checks.
module tb_atp;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_payment;
    logic [3:0]  barcode;
    logic [3:0]  choice;
    logic        cheque_inserted;
    logic [7:0]  cheque_amount;
    logic        dd_inserted;
    logic [7:0]  dd_amount;
    logic        card_inserted;
    logic [15:0] card_number;
    logic [3:0]  card_choice;
    logic [7:0]  card_amount;
    logic        currency_inserted;
    logic [7:0]  currency_amount;
    logic [7:0]  remaining_amount;
    logic        payment_complete;
    logic        line_disconnected;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cycle  = 0;

    logic [9:0] exp_q[$];

    atp #(.TIMEOUT(TIMEOUT)) dut (
        .clk               (clk),
        .reset             (reset),
        .start_payment     (start_payment),
        .barcode           (barcode),
        .choice            (choice),
        .cheque_inserted   (cheque_inserted),
        .cheque_amount     (cheque_amount),
        .dd_inserted       (dd_inserted),
        .dd_amount         (dd_amount),
        .card_inserted     (card_inserted),
        .card_number       (card_number),
        .card_choice       (card_choice),
        .card_amount       (card_amount),
        .currency_inserted (currency_inserted),
        .currency_amount   (currency_amount),
        .remaining_amount  (remaining_amount),
        .payment_complete  (payment_complete),
        .line_disconnected (line_disconnected),
        .state_dbg         (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model (session level) ----------------
    int m_rem, m_bar, m_amt, m_idle;
    bit m_comp, m_active, m_scanning, m_settled, m_pend, m_card_ok, m_prev_start;
    int m_method;  // 0 = choosing a method, 1..4 = waiting on that instrument

    task automatic m_abort();
        m_active = 0; m_scanning = 0; m_method = 0;
        m_rem = 0; m_comp = 0;
    endtask

    task automatic model_step();
        bit rise, ins;
        int amt;
        rise = start_payment && !m_prev_start;
        if (!reset) begin
            m_rem = 0; m_comp = 0; m_active = 0; m_scanning = 0; m_settled = 0;
            m_method = 0; m_pend = 0; m_amt = 0; m_card_ok = 0; m_idle = 0; m_bar = 0;
            m_prev_start = 0;
            return;
        end
        if (m_settled) begin
            m_settled = 0; m_active = 0;
        end else if (!m_active) begin
            if (rise) begin
                m_active = 1; m_scanning = 1; m_bar = barcode; m_comp = 0;
            end
        end else if (m_scanning) begin
            if (start_payment) m_bar = barcode;
            else if (m_bar != 0) begin
                m_rem = m_bar * 16; m_scanning = 0; m_method = 0; m_idle = 0; m_pend = 0;
            end else m_active = 0;
        end else if (rise) begin
            m_abort();
        end else if (m_method == 0) begin
            if (choice >= 1 && choice <= 4) begin
                m_method = choice; m_idle = 0; m_pend = 0;
            end else begin
                m_idle++;
                if (m_idle >= TIMEOUT) m_abort();
            end
        end else begin
            case (m_method)
                1: begin ins = cheque_inserted;   amt = cheque_amount;   end
                2: begin ins = dd_inserted;       amt = dd_amount;       end
                3: begin ins = card_inserted;     amt = card_amount;     end
                default: begin ins = currency_inserted; amt = currency_amount; end
            endcase
            if (ins) begin
                m_amt = amt;
                if (m_method == 3) m_card_ok = (card_number != 0) && (card_choice < 2);
            end
            if (m_pend && !ins) begin
                if (!(m_method == 3 && !m_card_ok)) begin
                    m_rem = (m_amt >= m_rem) ? 0 : m_rem - m_amt;
                end
                m_method = 0; m_idle = 0; m_pend = 0;
                if (m_rem == 0) begin
                    m_settled = 1; m_comp = 1;
                end
            end else if (ins != m_pend) begin
                m_idle = 0; m_pend = ins;
            end else begin
                m_idle++;
                if (m_idle >= TIMEOUT) m_abort();
            end
        end
        m_prev_start = start_payment;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        logic [9:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cycle++;
            n_checks++;
            if ({remaining_amount, payment_complete, line_disconnected} !== e) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got rem=%0d done=%0b line=%0b, want rem=%0d done=%0b line=%0b",
                         n_cycle, remaining_amount, payment_complete, line_disconnected,
                         e[9:2], e[1], e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_step();
            exp_q.push_back({8'(m_rem), m_comp, ~m_active});
            @(negedge clk);
        end
    endtask

    task automatic spot(input string name, input int rem, input bit comp, input bit line);
        n_checks++;
        if (remaining_amount !== 8'(rem) || payment_complete !== comp || line_disconnected !== line) begin
            n_fail++;
            $display("FAIL %s: got rem=%0d done=%0b line=%0b, want rem=%0d done=%0b line=%0b",
                     name, remaining_amount, payment_complete, line_disconnected, rem, comp, line);
        end
    endtask

    task automatic scan(input logic [3:0] bc);
        barcode = bc; start_payment = 1'b1; cyc();
        start_payment = 1'b0; cyc();
        barcode = 4'd0;
    endtask

    task automatic choose(input logic [3:0] c);
        choice = c; cyc();
        choice = 4'd0;
    endtask

    task automatic pay(input int kind, input logic [7:0] amt, input int hold);
        case (kind)
            1: begin cheque_inserted = 1'b1;   cheque_amount = amt;   end
            2: begin dd_inserted = 1'b1;       dd_amount = amt;       end
            3: begin card_inserted = 1'b1;     card_amount = amt;     end
            default: begin currency_inserted = 1'b1; currency_amount = amt; end
        endcase
        cyc(hold);
        cheque_inserted = 1'b0; dd_inserted = 1'b0;
        card_inserted = 1'b0; currency_inserted = 1'b0;
        cyc();
    endtask

    task automatic cancel_pulse();
        start_payment = 1'b1; cyc();
        start_payment = 1'b0; cyc();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0; start_payment = 1'b0; barcode = 4'd0; choice = 4'd0;
        cheque_inserted = 1'b0; cheque_amount = 8'd0; dd_inserted = 1'b0; dd_amount = 8'd0;
        card_inserted = 1'b0; card_number = 16'd0; card_choice = 4'd0; card_amount = 8'd0;
        currency_inserted = 1'b0; currency_amount = 8'd0;
        cyc(2);
        spot("reset", 0, 0, 1);
        reset = 1'b1;
        cyc();

        // Timeout in SELECT
        scan(4'd2);
        spot("scan2_select", 32, 0, 0);
        cyc(TIMEOUT + 2);
        spot("timeout_abort", 0, 0, 1);

        // Cheque overpayment settles the bill
        scan(4'd3);
        spot("scan3", 48, 0, 0);
        choose(4'd1);
        pay(1, 8'd50, 2);
        spot("cheque_done", 0, 1, 0);
        cyc();
        spot("cheque_idle", 0, 1, 1);

        // Valid debit card, then rejected card type
        scan(4'd4);
        spot("scan4_clears_complete", 64, 0, 0);
        card_number = 16'd1234; card_choice = 4'd0;
        choose(4'd3);
        pay(3, 8'd100, 2);
        cyc();
        spot("card_ok_idle", 0, 1, 1);
        scan(4'd4);
        card_choice = 4'd2;
        choose(4'd3);
        pay(3, 8'd100, 2);
        spot("card_rejected", 64, 0, 0);
        cancel_pulse();
        spot("card_cancel", 0, 0, 1);

        // Partial cash then DD
        scan(4'd5);
        choose(4'd4);
        pay(4, 8'd20, 1);
        spot("cash_partial", 60, 0, 0);
        choose(4'd2);
        pay(2, 8'd60, 3);
        cyc();
        spot("dd_settle_idle", 0, 1, 1);

        // Cancel from SELECT
        scan(4'd6);
        cyc();
        cancel_pulse();
        spot("select_cancel", 0, 0, 1);

        // Zero barcode, then reset mid-cash
        scan(4'd0);
        spot("zero_barcode", 0, 0, 1);
        scan(4'd1);
        choose(4'd4);
        currency_inserted = 1'b1; currency_amount = 8'd5;
        cyc();
        reset = 1'b0;
        cyc();
        spot("reset_mid_cash", 0, 0, 1);
        reset = 1'b1; currency_inserted = 1'b0;
        cyc();

        // Randomised sessions
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) start_payment = ~start_payment;
            barcode = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) choice = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) cheque_inserted = ~cheque_inserted;
            if ($urandom_range(0, 4) == 0) dd_inserted = ~dd_inserted;
            if ($urandom_range(0, 4) == 0) card_inserted = ~card_inserted;
            if ($urandom_range(0, 4) == 0) currency_inserted = ~currency_inserted;
            cheque_amount   = 8'($urandom_range(0, 255) >> $urandom_range(0, 3));
            dd_amount       = 8'($urandom_range(0, 255) >> $urandom_range(0, 3));
            card_amount     = 8'($urandom_range(0, 255) >> $urandom_range(0, 3));
            currency_amount = 8'($urandom_range(0, 255) >> $urandom_range(0, 3));
            card_number     = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            card_choice     = 4'($urandom_range(0, 3));
            reset           = ($urandom_range(0, 399) != 0);
            cyc();
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
